// File: rtl/fb_write_ctrl_if.sv
// rtl/fb_write_ctrl_if.sv - pixel, clear, memory and status signals of the framebuffer write controller
interface fb_write_ctrl_if;
    logic        pix_we;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [3:0]  pix_data;
    logic        clear_start;
    logic [3:0]  clear_color;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    modport master (
        input  pix_we, pix_x, pix_y, pix_data, clear_start, clear_color, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, fifo_full, overflow, busy
    );

    modport slave (
        output pix_we, pix_x, pix_y, pix_data, clear_start, clear_color, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, fifo_full, overflow, busy
    );
endinterface

// File: rtl/fb_write_ctrl.sv
// rtl/fb_write_ctrl.sv - queues 4-bit pixels and read-modify-writes them into a packed 16-bit framebuffer
module fb_write_ctrl #(
    parameter int FIFO_DEPTH = 32,
    parameter int FB_W       = 640,
    parameter int FB_H       = 480
) (
    input logic             clk,
    input logic             areset,
    fb_write_ctrl_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [16:0] ROW_WORDS = 17'(FB_W / 4);
    localparam logic [16:0] LAST_ADDR = 17'((FB_W / 4) * FB_H - 1);
    localparam logic [9:0]  W_LIM     = 10'(FB_W);
    localparam logic [9:0]  H_LIM     = 10'(FB_H);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WR, CLR} state_t;

    typedef struct packed {
        logic [16:0] addr;
        logic [1:0]  nib;
        logic [3:0]  data;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    entry_t        hold_q;
    logic [16:0]   clr_cnt_q;
    logic [3:0]    clr_color_q;
    logic          overflow_q;

    logic          in_range, full, empty, push, pop, clr_take;
    logic [16:0]   pix_addr;
    logic [16:0]   addr_c;
    logic [15:0]   wdata_c;
    logic          we_c, re_c;

    assign in_range = (bus.pix_x < W_LIM) && (bus.pix_y < H_LIM);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = bus.pix_we && in_range && !full;
    assign pix_addr = 17'(bus.pix_y) * ROW_WORDS + {9'd0, bus.pix_x[9:2]};

    always_ff @(posedge clk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // clear_start outranks a pending pixel; in WR/CLR it is simply not looked at
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        clr_take = 1'b0;
        re_c     = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    clr_take = 1'b1;
                    state_d  = CLR;
                end else if (!empty) begin
                    re_c    = 1'b1;
                    addr_c  = fifo_mem[rd_ptr].addr;
                    pop     = 1'b1;
                    state_d = WR;
                end
            end
            WR: begin
                we_c    = 1'b1;
                addr_c  = hold_q.addr;
                wdata_c = bus.mem_rdata;
                wdata_c[{hold_q.nib, 2'b00} +: 4] = hold_q.data;
                state_d = IDLE;
            end
            CLR: begin
                we_c    = 1'b1;
                addr_c  = clr_cnt_q;
                wdata_c = {4{clr_color_q}};
                if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (areset) begin
            pop      = 1'b0;
            clr_take = 1'b0;
            re_c     = 1'b0;
            we_c     = 1'b0;
            addr_c   = '0;
            wdata_c  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: pix_addr, nib: bus.pix_x[1:0], data: bus.pix_data};
    end

    // a pixel seen while full is dropped even if this cycle also pops
    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (bus.pix_we && in_range && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            hold_q      <= '0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
        end else begin
            if (pop) hold_q <= fifo_mem[rd_ptr];
            if (clr_take) begin
                clr_cnt_q   <= '0;
                clr_color_q <= bus.clear_color;
            end else if (state_q == CLR) begin
                clr_cnt_q <= clr_cnt_q + 17'd1;
            end
        end
    end

    assign bus.mem_re    = re_c;
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.fifo_full = full && !areset;
    assign bus.overflow  = overflow_q && !areset;
    assign bus.busy      = !areset && ((state_q != IDLE) || !empty);
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb/tb_fb_write_ctrl.sv - framebuffer write controller bench with transaction-level reference model
module tb_fb_write_ctrl;
    localparam int DEPTH = 32;
    localparam int WORDS = 76800;

    logic clk = 1'b0;
    logic areset;
    int   checks = 0;
    int   errors = 0;

    fb_write_ctrl_if bus ();

    fb_write_ctrl #(.FIFO_DEPTH(DEPTH), .FB_W(640), .FB_H(480)) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [WORDS];
    logic [15:0] ref_mem [WORDS];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr] : 16'h0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    typedef struct {
        int addr;
        int nib;
        int data;
    } pix_t;

    pix_t        pq[$];
    pix_t        m_hold;
    logic        m_wr = 1'b0;
    logic        m_clr = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_clr_addr = 0;
    logic [3:0]  m_col = 4'h0;
    logic        exp_re, exp_we, in_rng, was_full;
    logic [16:0] exp_addr;
    logic [15:0] exp_wd;

    // Reference: pending pixels in a queue, expected memory image, clear as an address sweep
    always @(negedge clk) begin
        if (areset) begin
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_re", bus.mem_re, 0);
            chk("rst_fifo_full", bus.fifo_full, 0);
            chk("rst_overflow", bus.overflow, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            pq.delete();
            m_wr = 1'b0;
            m_clr = 1'b0;
            m_ovf = 1'b0;
        end else begin
            exp_re = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
            if (m_clr) begin
                exp_we = 1'b1; exp_addr = 17'(m_clr_addr); exp_wd = {4{m_col}};
            end else if (m_wr) begin
                exp_we = 1'b1; exp_addr = 17'(m_hold.addr);
                exp_wd = ref_mem[m_hold.addr];
                exp_wd[m_hold.nib*4 +: 4] = 4'(m_hold.data);
            end else if (!bus.clear_start && pq.size() > 0) begin
                exp_re = 1'b1; exp_addr = 17'(pq[0].addr);
            end
            chk("mem_re", bus.mem_re, exp_re);
            chk("mem_we", bus.mem_we, exp_we);
            chk("mem_addr", bus.mem_addr, exp_addr);
            chk("mem_wdata", bus.mem_wdata, exp_wd);
            chk("fifo_full", bus.fifo_full, pq.size() == DEPTH);
            chk("overflow", bus.overflow, m_ovf);
            chk("busy", bus.busy, m_wr || m_clr || pq.size() != 0);

            in_rng   = bus.pix_we && bus.pix_x < 640 && bus.pix_y < 480;
            was_full = (pq.size() == DEPTH);
            if (exp_re) begin
                m_hold = pq.pop_front();
                m_wr = 1'b1;
            end else if (m_wr) begin
                ref_mem[m_hold.addr] = exp_wd;
                m_wr = 1'b0;
            end else if (m_clr) begin
                ref_mem[m_clr_addr] = exp_wd;
                m_clr_addr++;
                if (m_clr_addr == WORDS) m_clr = 1'b0;
            end else if (bus.clear_start) begin
                m_clr = 1'b1; m_clr_addr = 0; m_col = bus.clear_color;
            end
            if (in_rng) begin
                if (was_full) m_ovf = 1'b1;
                else pq.push_back('{addr: int'(bus.pix_y) * 160 + int'(bus.pix_x) / 4,
                                   nib: int'(bus.pix_x) % 4, data: int'(bus.pix_data)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input int d);
        bus.pix_we = 1'b1; bus.pix_x = 10'(x); bus.pix_y = 10'(y); bus.pix_data = 4'(d);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic found;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 16'h0; ref_mem[i] = 16'h0;
        end
        mem[321] = 16'h1234; ref_mem[321] = 16'h1234;
        bus.clear_start = 1'b0; bus.clear_color = 4'h0;
        areset = 1'b1;
        drive_pix(3, 3, 7);
        tick(); tick();
        areset = 1'b0; bus.pix_we = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_full", bus.fifo_full, 0);

        // single pixel read-modify-write on preloaded word 321
        tick(); drive_pix(5, 2, 4'hA);
        tick(); bus.pix_we = 1'b0;
        @(negedge clk);
        chk("rmw_c1_re", bus.mem_re, 1);
        chk("rmw_c1_addr", bus.mem_addr, 321);
        tick(); @(negedge clk);
        chk("rmw_c2_we", bus.mem_we, 1);
        chk("rmw_c2_addr", bus.mem_addr, 321);
        chk("rmw_c2_wdata", bus.mem_wdata, 16'h12A4);
        tick(); @(negedge clk);
        chk("rmw_c3_busy", bus.busy, 0);

        // out-of-range pixels vanish
        tick(); drive_pix(640, 0, 1);
        tick(); drive_pix(0, 480, 2);
        tick(); bus.pix_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("oor_access", bus.mem_we | bus.mem_re, 0);
            chk("oor_busy", bus.busy, 0);
            chk("oor_overflow", bus.overflow, 0);
            tick();
        end

        // two nibbles into word 0, clear_start during WR ignored
        drive_pix(0, 0, 1);
        tick(); drive_pix(1, 0, 2);
        tick(); bus.pix_we = 1'b0; bus.clear_start = 1'b1; bus.clear_color = 4'h7;
        tick(); bus.clear_start = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("wr_clr_busy", bus.busy, 0);
        chk("word0", mem[0], 16'h0021);

        // clear interrupted by reset at counter 1000 with pixels queued
        tick(); bus.clear_start = 1'b1; bus.clear_color = 4'h3;
        tick(); bus.clear_start = 1'b0; drive_pix(10, 10, 1);
        tick(); drive_pix(20, 20, 2);
        tick(); drive_pix(30, 30, 3);
        tick(); bus.pix_we = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1500 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_addr == 17'd999) found = 1'b1;
            tick();
        end
        chk("clr_reach_1000", found, 1);
        areset = 1'b1;
        tick(); areset = 1'b0;
        @(negedge clk);
        chk("abort_we", bus.mem_we, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_full", bus.fifo_full, 0);
        chk("abort_w999", mem[999], 16'h3333);
        chk("abort_w1000", mem[1000], 16'h0000);

        // full clear with a 64-pixel burst overrunning the FIFO
        tick(); bus.clear_start = 1'b1; bus.clear_color = 4'h5;
        tick(); bus.clear_start = 1'b0;
        @(negedge clk);
        chk("clr_first_we", bus.mem_we, 1);
        chk("clr_first_addr", bus.mem_addr, 0);
        chk("clr_first_wdata", bus.mem_wdata, 16'h5555);
        for (int i = 0; i < 64; i++) begin
            tick(); drive_pix(4 * i, 100, i % 16);
        end
        tick(); bus.pix_we = 1'b0;
        @(negedge clk);
        chk("burst_full", bus.fifo_full, 1);
        chk("burst_overflow", bus.overflow, 1);
        found = 1'b0;
        for (int k = 0; k < 80000 && !found; k++) begin
            tick(); @(negedge clk);
            if (!bus.busy) found = 1'b1;
        end
        chk("clr_done", found, 1);
        chk("w16000", mem[16000], 16'h5550);
        chk("w16031", mem[16031], 16'h555F);
        chk("w16032_dropped", mem[16032], 16'h5555);
        chk("w16063_dropped", mem[16063], 16'h5555);
        chk("w76799", mem[76799], 16'h5555);

        tick(); areset = 1'b1;
        tick(); areset = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", bus.overflow, 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): FIFO_DEPTH, 32, pixel FIFO entries; FB_W, 640, pixels per line; FB_H, 480, lines.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- areset, in, 1, reset, synchronous, active-high.
- pix_we, in, 1, pixel write strobe from the rasterizer.
- pix_x, in, 10, pixel column.
- pix_y, in, 10, pixel row.
- pix_data, in, 4, pixel colour index.
- clear_start, in, 1, one-cycle request to fill the framebuffer.
- clear_color, in, 4, fill colour, sampled with clear_start.
- mem_addr, out, 17, word address.
- mem_wdata, out, 16, write data.
- mem_we, out, 1, write strobe.
- mem_re, out, 1, read strobe.
- mem_rdata, in, 16, read data, valid exactly 1 cycle after mem_re.
- fifo_full, out, 1, FIFO holds FIFO_DEPTH entries.
- overflow, out, 1, sticky flag: a valid pixel was dropped.
- busy, out, 1, work pending.

Function
REQ-003 Each framebuffer word SHALL pack 4 pixels: word address = pix_y*160 + pix_x[9:2]; nibble index n = pix_x[1:0]; pixel occupies bits 4n+3:4n.
REQ-004 A pixel with pix_we=1 SHALL be enqueued at the clock edge only if pix_x<FB_W, pix_y<FB_H and the FIFO is not full.
REQ-005 An out-of-range pixel SHALL be discarded silently and SHALL NOT set overflow.
REQ-006 An in-range pixel arriving while fifo_full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-007 A FIFO entry SHALL hold {word address 17b, nibble 2b, data 4b}; the FIFO SHALL be first-in first-out with wrap-around pointers, and simultaneous push and pop SHALL be supported.
REQ-008 The FSM SHALL have states IDLE, WR and CLR.
REQ-009 IDLE, clear_start=1: the block SHALL latch clear_color, set the clear counter to 0 and go to CLR; clear_start SHALL take priority over the FIFO.
REQ-010 IDLE, FIFO not empty: the block SHALL drive mem_re=1 and mem_addr=head address, pop the head into a hold register and go to WR.
REQ-011 WR: the block SHALL drive mem_we=1, mem_addr=hold address, and mem_wdata=mem_rdata with nibble n replaced by the hold data (other nibbles unchanged), then go to IDLE; each pixel therefore takes 2 cycles.
REQ-012 CLR: each cycle the block SHALL drive mem_we=1, mem_addr=counter and mem_wdata={4{color}}, then increment the counter; after writing address 76799 it SHALL go to IDLE.
REQ-013 During CLR, pixel writes SHALL still be enqueued per REQ-004..006 and SHALL be processed after the clear.
REQ-014 clear_start SHALL be ignored in WR and CLR.
REQ-015 mem_re and mem_we SHALL never be asserted in the same cycle.
REQ-016 When neither mem_re nor mem_we is asserted, mem_addr and mem_wdata SHALL be 0.
REQ-017 busy SHALL equal (state != IDLE) OR FIFO not empty.
REQ-018 fifo_full SHALL be combinational from the FIFO count.

Reset
REQ-019 With areset=1 at a clock edge, the block SHALL enter IDLE, empty the FIFO, and clear overflow, the hold register and the clear counter.
REQ-020 During the reset cycle and the cycle after it, outputs SHALL be mem_we=0, mem_re=0, fifo_full=0, overflow=0, busy=0, mem_addr=0 and mem_wdata=0.
REQ-021 areset asserted mid-WR or mid-CLR SHALL abort the operation with no further memory access; words already written remain.
REQ-022 pix_we asserted in the same cycle as areset SHALL be discarded.

Verification
REQ-023 Word 321 preloaded 0x1234; pix (5,2) data 0xA at cycle 0 -> cycle 1: mem_re=1, addr 321; cycle 2: mem_we=1, addr 321, wdata 0x12A4; busy=0 at cycle 3.
REQ-024 clear_start with clear_color 0x5 in IDLE -> 76800 consecutive writes of 0x5555 to addresses 0..76799, one per cycle; then busy=0.
REQ-025 pix_we=1 on 64 consecutive cycles, all in-range distinct words -> fifo_full asserts, overflow=1, no dropped pixel is ever written, and enqueued pixels are written in order.
REQ-026 pix (640,0) and pix (0,480) -> no mem_re or mem_we, overflow=0, busy stays 0.
REQ-027 areset asserted at clear counter 1000 with 3 pixels queued -> next cycle mem_we=0, busy=0, FIFO empty; a subsequent clear_start restarts at address 0.
REQ-028 clear_start during WR -> ignored, no CLR entry; pixels (0,0) 0x1 and (1,0) 0x2 queued back-to-back on word 0 = 0x0000 -> word 0 ends 0x0021.
